// File: rtl/hba_gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hba_gpio_pkg
// Description : Shared definitions for the parametrised HBA GPIO slave:
//               register function codes, function count and the bus-slave
//               FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package hba_gpio_pkg;

    // Register index r = func * NUM_BANKS + bank
    localparam int FUNC_OUT_EN     = 0;
    localparam int FUNC_OUT_SIG    = 1;
    localparam int FUNC_IN_SIG     = 2;
    localparam int FUNC_IRQ_EN     = 3;
    localparam int FUNC_IRQ_EDGE   = 4;
    localparam int FUNC_IRQ_STATUS = 5;
    localparam int NUM_FUNCS       = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hba_gpio_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : hba_gpio_multi_if
// Description : HBA bus bundle between the serial_fpga master and a slave.
//               master : drives rnw/select/abus/dbus, receives read data/ack
//               slave  : receives rnw/select/abus/dbus, drives read data/ack
// Revision    : 1.0 - initial release
// ============================================================================
interface hba_gpio_multi_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DBUS_WIDTH = 8
);
    logic                  hba_rnw;
    logic                  hba_select;
    logic [ADDR_WIDTH-1:0] hba_abus;
    logic [DBUS_WIDTH-1:0] hba_dbus;
    logic [DBUS_WIDTH-1:0] gpio_dbus;
    logic                  gpio_xferack;

    modport master (
        output hba_rnw, hba_select, hba_abus, hba_dbus,
        input  gpio_dbus, gpio_xferack
    );

    modport slave (
        input  hba_rnw, hba_select, hba_abus, hba_dbus,
        output gpio_dbus, gpio_xferack
    );
endinterface
`default_nettype wire

// File: rtl/hba_gpio_pin_in.sv
`default_nettype none
// ============================================================================
// Module      : hba_gpio_pin_in
// Description : One GPIO input path: 2-flop synchroniser, optional debounce
//               filter (GPIO_DEBOUNCE_EN) and edge detector.
// Ports       : clk     - clock
//               rst_n   - synchronous reset, active-low
//               i_pin   - asynchronous pin input
//               o_level - synchronised (and filtered) level
//               o_rise  - one-cycle rising-edge strobe
//               o_fall  - one-cycle falling-edge strobe
// Macro       : GPIO_DEBOUNCE_EN adds the DEBOUNCE_CYCLES filter.
// Revision    : 1.0 - initial release
// ============================================================================
module hba_gpio_pin_in
`ifdef GPIO_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 16
)
`endif
(
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_pin,
    output logic      o_level,
    output logic      o_rise,
    output logic      o_fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_level;

    // r_prev resets to 0, so a pin held high at reset release yields a rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            r_prev  <= w_level;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_filt;

    // The filtered level follows only after DEBOUNCE_CYCLES consecutive
    // cycles of disagreement; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (r_sync2 != r_filt) begin
            if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_filt <= r_sync2;
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + CW'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync2;
`endif

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_prev;
    assign o_fall  = ~w_level & r_prev;

endmodule
`default_nettype wire

// File: rtl/hba_gpio_multi.sv
`default_nettype none
// ============================================================================
// Module      : hba_gpio_multi
// Description : Parametrised HBA GPIO slave with NUM_PINS bidirectional pins
//               banked over DBUS_WIDTH-wide registers, per-pin edge interrupts
//               and write-1-to-clear status.
// Ports       : hba_clk        - clock
//               hba_reset      - synchronous reset, active-low
//               bus            - HBA slave modport (rnw/select/abus/dbus in,
//                                gpio_dbus/gpio_xferack out, 0 when idle)
//               gpio_interrupt - registered OR of pending status
//               gpio_out_en    - per-pin drive enable
//               gpio_out_sig   - per-pin drive value
//               gpio_in_sig    - asynchronous pin inputs
// Macro       : GPIO_DEBOUNCE_EN enables the input debounce filter.
// Revision    : 1.0 - initial release
// ============================================================================
module hba_gpio_multi
    import hba_gpio_pkg::*;
#(
    parameter int DBUS_WIDTH        = 8,
    parameter int PERIPH_ADDR_WIDTH = 4,
    parameter int REG_ADDR_WIDTH    = 8,
    parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
    parameter int PERIPH_ADDR       = 0,
    parameter int NUM_PINS          = 8
`ifdef GPIO_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES   = 16
`endif
) (
    input  wire logic          hba_clk,
    input  wire logic          hba_reset,
    hba_gpio_multi_if.slave    bus,
    output logic               gpio_interrupt,
    output logic [NUM_PINS-1:0] gpio_out_en,
    output logic [NUM_PINS-1:0] gpio_out_sig,
    input  wire logic [NUM_PINS-1:0] gpio_in_sig
);

    localparam int NUM_BANKS = (NUM_PINS + DBUS_WIDTH - 1) / DBUS_WIDTH;
    localparam int NF        = NUM_FUNCS * NUM_PINS;

    state_t                  r_state;
    logic                    r_xferack;
    logic [DBUS_WIDTH-1:0]   r_rdata;
    logic [NUM_PINS-1:0]     r_out_en;
    logic [NUM_PINS-1:0]     r_out_sig;
    logic [NUM_PINS-1:0]     r_irq_en;
    logic [NUM_PINS-1:0]     r_irq_edge;
    logic [NUM_PINS-1:0]     r_status;
    logic                    r_irq;

    logic [PERIPH_ADDR_WIDTH-1:0] w_periph;
    logic [REG_ADDR_WIDTH-1:0]    w_reg_idx;
    logic                         w_hit;
    logic                         w_commit;
    logic [NUM_PINS-1:0]          w_level, w_rise, w_fall;
    logic [NUM_PINS-1:0]          w_wdata;
    logic [NUM_PINS-1:0]          w_rd_pin;
    logic [NF-1:0]                w_sel;   // [f*NUM_PINS + pin]: pin is addressed as func f
    logic [NF-1:0]                w_val;   // [f*NUM_PINS + pin]: current value of func f
    logic [DBUS_WIDTH-1:0]        w_rd_data;
    logic [NUM_PINS-1:0]          w_set, w_clr;
    logic [NUM_PINS-1:0]          w_sel_out_en, w_sel_out_sig, w_sel_irq_en;
    logic [NUM_PINS-1:0]          w_sel_irq_edge, w_sel_status;

    assign w_periph  = bus.hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH];
    assign w_reg_idx = bus.hba_abus[REG_ADDR_WIDTH-1:0];
    assign w_hit     = bus.hba_select && (w_periph == PERIPH_ADDR_WIDTH'(PERIPH_ADDR));

    assign w_val[FUNC_OUT_EN*NUM_PINS     +: NUM_PINS] = r_out_en;
    assign w_val[FUNC_OUT_SIG*NUM_PINS    +: NUM_PINS] = r_out_sig;
    assign w_val[FUNC_IN_SIG*NUM_PINS     +: NUM_PINS] = w_level;
    assign w_val[FUNC_IRQ_EN*NUM_PINS     +: NUM_PINS] = r_irq_en;
    assign w_val[FUNC_IRQ_EDGE*NUM_PINS   +: NUM_PINS] = r_irq_edge;
    assign w_val[FUNC_IRQ_STATUS*NUM_PINS +: NUM_PINS] = r_status;

    assign w_sel_out_en   = w_sel[FUNC_OUT_EN*NUM_PINS     +: NUM_PINS];
    assign w_sel_out_sig  = w_sel[FUNC_OUT_SIG*NUM_PINS    +: NUM_PINS];
    assign w_sel_irq_en   = w_sel[FUNC_IRQ_EN*NUM_PINS     +: NUM_PINS];
    assign w_sel_irq_edge = w_sel[FUNC_IRQ_EDGE*NUM_PINS   +: NUM_PINS];
    assign w_sel_status   = w_sel[FUNC_IRQ_STATUS*NUM_PINS +: NUM_PINS];

    // Per-pin input path and address decode. Only one register index can
    // match, so at most one function bit per pin is selected.
    for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pin
        localparam int BANK = gi / DBUS_WIDTH;
        localparam int BIT  = gi % DBUS_WIDTH;

`ifdef GPIO_DEBOUNCE_EN
        hba_gpio_pin_in #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_pin_in (
            .clk     (hba_clk),
            .rst_n   (hba_reset),
            .i_pin   (gpio_in_sig[gi]),
            .o_level (w_level[gi]),
            .o_rise  (w_rise[gi]),
            .o_fall  (w_fall[gi])
        );
`else
        hba_gpio_pin_in u_pin_in (
            .clk     (hba_clk),
            .rst_n   (hba_reset),
            .i_pin   (gpio_in_sig[gi]),
            .o_level (w_level[gi]),
            .o_rise  (w_rise[gi]),
            .o_fall  (w_fall[gi])
        );
`endif

        logic [NUM_FUNCS-1:0] w_hit_f;

        assign w_wdata[gi] = bus.hba_dbus[BIT];

        for (genvar gf = 0; gf < NUM_FUNCS; gf++) begin : g_func
            assign w_sel[gf*NUM_PINS + gi] = (int'(w_reg_idx) == gf * NUM_BANKS + BANK);
            assign w_hit_f[gf] = w_sel[gf*NUM_PINS + gi] & w_val[gf*NUM_PINS + gi];
        end

        assign w_rd_pin[gi] = |w_hit_f;
    end

    // Gather each data-bus bit from the pins that share that bank position;
    // positions past NUM_PINS contribute 0.
    for (genvar gj = 0; gj < DBUS_WIDTH; gj++) begin : g_rd_bit
        logic [NUM_BANKS-1:0] w_col;
        for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
            if (gb * DBUS_WIDTH + gj < NUM_PINS) begin : g_mapped
                assign w_col[gb] = w_rd_pin[gb * DBUS_WIDTH + gj];
            end else begin : g_unmapped
                assign w_col[gb] = 1'b0;
            end
        end
        assign w_rd_data[gj] = |w_col;
    end

    // A write lands on the edge that ends the ACK cycle.
    assign w_commit = (r_state == ACK) && !bus.hba_rnw;

    assign w_set = r_irq_en & ((r_irq_edge & w_rise) | (~r_irq_edge & w_fall));
    assign w_clr = {NUM_PINS{w_commit}} & w_sel_status & w_wdata;

    always_ff @(posedge hba_clk) begin
        if (!hba_reset) begin
            r_state    <= IDLE;
            r_xferack  <= 1'b0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_state   <= ACK;
                        r_xferack <= 1'b1;
                        r_rdata   <= bus.hba_rnw ? w_rd_data : '0;
                    end
                end
                ACK: begin
                    r_state   <= WAIT;
                    r_xferack <= 1'b0;
                    r_rdata   <= '0;
                end
                WAIT: begin
                    if (!bus.hba_select) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_xferack <= 1'b0;
                    r_rdata   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge hba_clk) begin
        if (!hba_reset) begin
            r_out_en   <= '0;
            r_out_sig  <= '0;
            r_irq_en   <= '0;
            r_irq_edge <= '0;
            r_status   <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_commit) begin
                r_out_en   <= (r_out_en   & ~w_sel_out_en)   | (w_wdata & w_sel_out_en);
                r_out_sig  <= (r_out_sig  & ~w_sel_out_sig)  | (w_wdata & w_sel_out_sig);
                r_irq_en   <= (r_irq_en   & ~w_sel_irq_en)   | (w_wdata & w_sel_irq_en);
                r_irq_edge <= (r_irq_edge & ~w_sel_irq_edge) | (w_wdata & w_sel_irq_edge);
            end
            // A new edge outranks a simultaneous clear.
            r_status <= (r_status & ~w_clr) | w_set;
            r_irq    <= |r_status;
        end
    end

    assign bus.gpio_dbus    = r_rdata;
    assign bus.gpio_xferack = r_xferack;
    assign gpio_interrupt   = r_irq;
    assign gpio_out_en      = r_out_en;
    assign gpio_out_sig     = r_out_sig;

endmodule
`default_nettype wire

// File: tb/tb_hba_gpio_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_hba_gpio_multi
// Description : Self-checking bench for hba_gpio_multi (NUM_PINS=12,
//               PERIPH_ADDR=2). Register table vectors plus hand-written
//               interrupt, coincidence and reset sequences; read data is
//               checked through an expected-value queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hba_gpio_multi;

    localparam int DW  = 8;
    localparam int PAW = 4;
    localparam int RAW = 8;
    localparam int AW  = PAW + RAW;
    localparam int NP  = 12;
    localparam int PA  = 2;
`ifdef GPIO_DEBOUNCE_EN
    localparam int DEB = 4;
`else
    localparam int DEB = 0;
`endif
    localparam int LAT = 3 + DEB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NP-1:0] out_en, out_sig, in_sig;
    logic          irq;

    always #5 clk = ~clk;

    hba_gpio_multi_if #(.ADDR_WIDTH(AW), .DBUS_WIDTH(DW)) bus ();

`ifdef GPIO_DEBOUNCE_EN
    hba_gpio_multi #(
        .DBUS_WIDTH(DW), .PERIPH_ADDR_WIDTH(PAW), .REG_ADDR_WIDTH(RAW),
        .ADDR_WIDTH(AW), .PERIPH_ADDR(PA), .NUM_PINS(NP), .DEBOUNCE_CYCLES(DEB)
    ) dut (
`else
    hba_gpio_multi #(
        .DBUS_WIDTH(DW), .PERIPH_ADDR_WIDTH(PAW), .REG_ADDR_WIDTH(RAW),
        .ADDR_WIDTH(AW), .PERIPH_ADDR(PA), .NUM_PINS(NP)
    ) dut (
`endif
        .hba_clk        (clk),
        .hba_reset      (rst_n),
        .bus            (bus),
        .gpio_interrupt (irq),
        .gpio_out_en    (out_en),
        .gpio_out_sig   (out_sig),
        .gpio_in_sig    (in_sig)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        bit         rnw;
        logic [7:0] r;
        logic [7:0] wd;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One bus transfer held for 'hold' cycles; counts acks, checks their
    // position, read data (via queue) and an idle-zero data bus.
    task automatic xfer(input bit rnw, input logic [3:0] per, input logic [7:0] r,
                        input logic [7:0] wd, input logic [7:0] exp, input int hold,
                        input bit expect_ack, input string name);
        int acks    = 0;
        int ack_cyc = -1;
        @(posedge clk); #1;
        bus.hba_rnw    = rnw;
        bus.hba_abus   = {per, r};
        bus.hba_dbus   = wd;
        bus.hba_select = 1'b1;
        if (rnw && expect_ack) exp_q.push_back(exp);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            if (bus.gpio_xferack) begin
                acks++;
                if (ack_cyc < 0) ack_cyc = c;
                if (rnw) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL %s_extra_ack actual=ack required=none", name);
                    end else begin
                        check({name, "_rdata"}, 32'(bus.gpio_dbus), 32'(exp_q.pop_front()));
                    end
                end
            end else begin
                check({name, "_idle_dbus"}, 32'(bus.gpio_dbus), 32'h0);
            end
        end
        @(posedge clk); #1;
        bus.hba_select = 1'b0;
        check({name, "_acks"}, 32'(acks), expect_ack ? 32'd1 : 32'd0);
        if (expect_ack) check({name, "_ack_cycle"}, 32'(ack_cyc), 32'd1);
        if (acks == 0) exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.hba_rnw    = 1'b0;
        bus.hba_select = 1'b0;
        bus.hba_abus   = '0;
        bus.hba_dbus   = '0;
        in_sig         = 12'h5A3;
        rst_n          = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_en",  32'(out_en), 32'h0);
        check("rst_out_sig", 32'(out_sig), 32'h0);
        check("rst_irq",     32'(irq), 32'h0);
        check("rst_ack",     32'(bus.gpio_xferack), 32'h0);
        check("rst_dbus",    32'(bus.gpio_dbus), 32'h0);

        // Register map: regs 0..11 mapped (2 banks x 6 funcs), 12+ unmapped
        tbl.push_back('{1'b0, 8'd0,  8'hFF, 8'h00});
        tbl.push_back('{1'b0, 8'd1,  8'hFF, 8'h00});
        tbl.push_back('{1'b1, 8'd0,  8'h00, 8'hFF});
        tbl.push_back('{1'b1, 8'd1,  8'h00, 8'h0F});
        tbl.push_back('{1'b0, 8'd2,  8'hA5, 8'h00});
        tbl.push_back('{1'b0, 8'd3,  8'h3C, 8'h00});
        tbl.push_back('{1'b1, 8'd2,  8'h00, 8'hA5});
        tbl.push_back('{1'b1, 8'd3,  8'h00, 8'h0C});
        tbl.push_back('{1'b1, 8'd4,  8'h00, 8'hA3});
        tbl.push_back('{1'b1, 8'd5,  8'h00, 8'h05});
        tbl.push_back('{1'b0, 8'd6,  8'h08, 8'h00});
        tbl.push_back('{1'b1, 8'd6,  8'h00, 8'h08});
        tbl.push_back('{1'b0, 8'd8,  8'h08, 8'h00});
        tbl.push_back('{1'b1, 8'd8,  8'h00, 8'h08});
        tbl.push_back('{1'b1, 8'd10, 8'h00, 8'h00});
        tbl.push_back('{1'b1, 8'd11, 8'h00, 8'h00});
        tbl.push_back('{1'b1, 8'd12, 8'h00, 8'h00});
        tbl.push_back('{1'b1, 8'd40, 8'h00, 8'h00});
        tbl.push_back('{1'b0, 8'd40, 8'hFF, 8'h00});
        tbl.push_back('{1'b0, 8'd12, 8'h00, 8'h00});
        tbl.push_back('{1'b1, 8'd0,  8'h00, 8'hFF});
        tbl.push_back('{1'b1, 8'd1,  8'h00, 8'h0F});
        tbl.push_back('{1'b1, 8'd2,  8'h00, 8'hA5});
        tbl.push_back('{1'b1, 8'd6,  8'h00, 8'h08});
        tbl.push_back('{1'b1, 8'd7,  8'h00, 8'h00});
        tbl.push_back('{1'b1, 8'd8,  8'h00, 8'h08});

        foreach (tbl[k]) begin
            xfer(tbl[k].rnw, 4'(PA), tbl[k].r, tbl[k].wd, tbl[k].exp, 3, 1'b1,
                 $sformatf("vec%0d_r%0d", k, tbl[k].r));
        end
        check("pins_out_en",  32'(out_en), 32'hFFF);
        check("pins_out_sig", 32'(out_sig), 32'hCA5);

        // Long select: one ack, in the second cycle; other periph never acked
        xfer(1'b1, 4'(PA), 8'd0, 8'h00, 8'hFF, 5, 1'b1, "hold5");
        xfer(1'b1, 4'd3,   8'd0, 8'h00, 8'h00, 5, 1'b0, "wrong_periph");
        xfer(1'b0, 4'd3,   8'd0, 8'h00, 8'h00, 5, 1'b0, "wrong_periph_wr");
        check("wrong_periph_no_write", 32'(out_en), 32'hFFF);

        // Rising edge on pin 3: status LAT edges later, interrupt one more
        @(posedge clk); #1 in_sig[3] = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        check("rise_irq_before", 32'(irq), 32'h0);
        @(negedge clk);
        check("rise_irq_after", 32'(irq), 32'h1);
        xfer(1'b1, 4'(PA), 8'd10, 8'h00, 8'h08, 3, 1'b1, "status_rise");
        xfer(1'b0, 4'(PA), 8'd10, 8'h08, 8'h00, 3, 1'b1, "w1c_pin3");
        @(negedge clk);
        check("w1c_irq_drop", 32'(irq), 32'h0);
        xfer(1'b1, 4'(PA), 8'd10, 8'h00, 8'h00, 3, 1'b1, "status_cleared");

        // Falling edge on pin 10 landing on the W1C commit edge: set wins
        xfer(1'b0, 4'(PA), 8'd7, 8'h04, 8'h00, 3, 1'b1, "irq_en_pin10");
        @(posedge clk); #1 in_sig[10] = 1'b0;
        repeat (DEB) @(posedge clk);
        xfer(1'b0, 4'(PA), 8'd11, 8'h04, 8'h00, 3, 1'b1, "w1c_coincident");
        xfer(1'b1, 4'(PA), 8'd11, 8'h00, 8'h04, 3, 1'b1, "status_kept");
        @(negedge clk);
        check("coincident_irq", 32'(irq), 32'h1);

        // Reset in the hit cycle: no ack, everything cleared
        @(posedge clk); #1;
        bus.hba_rnw    = 1'b1;
        bus.hba_abus   = {4'(PA), 8'd0};
        bus.hba_select = 1'b1;
        rst_n          = 1'b0;
        begin
            int acks = 0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (bus.gpio_xferack) acks++;
            end
            check("rst_hit_acks", 32'(acks), 32'h0);
        end
        check("rst_mid_out_en",  32'(out_en), 32'h0);
        check("rst_mid_out_sig", 32'(out_sig), 32'h0);
        check("rst_mid_irq",     32'(irq), 32'h0);
        check("rst_mid_dbus",    32'(bus.gpio_dbus), 32'h0);
        @(posedge clk); #1;
        bus.hba_select = 1'b0;
        rst_n          = 1'b1;

        // Reset during ACK: the write is aborted
        @(posedge clk); #1;
        bus.hba_rnw    = 1'b0;
        bus.hba_abus   = {4'(PA), 8'd0};
        bus.hba_dbus   = 8'h55;
        bus.hba_select = 1'b1;
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("ack_before_rst", 32'(bus.gpio_xferack), 32'h1);
        @(negedge clk);
        check("ack_after_rst", 32'(bus.gpio_xferack), 32'h0);
        check("aborted_write", 32'(out_en), 32'h0);
        @(posedge clk); #1;
        bus.hba_select = 1'b0;
        rst_n          = 1'b1;
        repeat (LAT + 2) @(posedge clk);
        xfer(1'b1, 4'(PA), 8'd0, 8'h00, 8'h00, 3, 1'b1, "post_rst_out_en");
        xfer(1'b1, 4'(PA), 8'd6, 8'h00, 8'h00, 3, 1'b1, "post_rst_irq_en");
        @(negedge clk);
        check("post_rst_irq", 32'(irq), 32'h0);

`ifdef GPIO_DEBOUNCE_EN
        // Debounce: 3-cycle glitch filtered, 6-cycle pulse accepted
        @(posedge clk); #1 in_sig[0] = 1'b0;
        repeat (12) @(posedge clk);
        xfer(1'b0, 4'(PA), 8'd6, 8'h01, 8'h00, 3, 1'b1, "deb_irq_en");
        xfer(1'b0, 4'(PA), 8'd8, 8'h01, 8'h00, 3, 1'b1, "deb_irq_edge");
        @(posedge clk); #1 in_sig[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 in_sig[0] = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("deb_glitch_irq", 32'(irq), 32'h0);
        @(posedge clk); #1 in_sig[0] = 1'b1;
        repeat (6) @(posedge clk);
        #1 in_sig[0] = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("deb_pulse_irq", 32'(irq), 32'h1);
        xfer(1'b1, 4'(PA), 8'd10, 8'h00, 8'h01, 3, 1'b1, "deb_status");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hba_gpio_multi.md
Name: hba_gpio_multi

Overview:
Parametrised successor to the 4-pin HBA GPIO slave. It provides NUM_PINS bidirectional GPIO pins, banked across DBUS_WIDTH-wide registers. Each pin has a 2-flop input synchroniser and per-pin edge-triggered interrupts with write-1-to-clear status. It is an HBA bus slave that sits beside other peripherals under the serial_fpga master; its read data and xferack are ORed onto the shared bus.

Parameters:
DBUS_WIDTH, 8, data bus width; also the number of pins per bank
PERIPH_ADDR_WIDTH, 4, width of the peripheral-select field of hba_abus
REG_ADDR_WIDTH, 8, width of the register field of hba_abus
ADDR_WIDTH, PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH, total address width
PERIPH_ADDR, 0, peripheral number this slave answers to
NUM_PINS, 8, GPIO pin count, legal range 1..32
NUM_BANKS, ceil(NUM_PINS/DBUS_WIDTH), derived; not to be overridden
DEBOUNCE_CYCLES, 16, stable-input cycles required (only with GPIO_DEBOUNCE_EN)

Ports:
hba_clk  in  1  single clock
hba_reset  in  1  synchronous reset, active-low (0 = reset)
hba_rnw  in  1  1=read, 0=write
hba_select  in  1  transfer in progress
hba_abus  in  ADDR_WIDTH  {periph, reg} address
hba_dbus  in  DBUS_WIDTH  write data
gpio_dbus  out  DBUS_WIDTH  read data; 0 when not acking
gpio_xferack  out  1  transfer acknowledge; 0 when inactive
gpio_interrupt  out  1  level interrupt, OR of pending status
gpio_out_en  out  NUM_PINS  1 = pin driven
gpio_out_sig  out  NUM_PINS  drive value
gpio_in_sig  in  NUM_PINS  asynchronous pin inputs

Behaviour:
- Hit = hba_select & (hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH] == PERIPH_ADDR).
- Register index r = func*NUM_BANKS + bank, where bank b covers pins [b*DBUS_WIDTH +: DBUS_WIDTH].
- Register functions:
  - func 0 OUT_EN (R/W)
  - func 1 OUT_SIG (R/W)
  - func 2 IN_SIG (RO, synchronised value)
  - func 3 IRQ_EN (R/W)
  - func 4 IRQ_EDGE (R/W; 1=rising, 0=falling)
  - func 5 IRQ_STATUS (R, W1C)
- Bank bits above NUM_PINS read 0 and ignore writes. Unmapped r (>= 6*NUM_BANKS) reads 0, ignores writes, and is still acked.
- Slave FSM:
  - IDLE: on hit, go to ACK.
  - ACK: gpio_xferack=1 for exactly one cycle. A write commits at this edge. For a read, gpio_dbus = register value during this cycle only. Next state WAIT.
  - WAIT: hold until hba_select=0, then go to IDLE. Exactly one ack per select assertion.
- Latency: ack is the cycle after the hit is first seen.
- Input path: in_sig passes through two flops to give sync. An edge is detected against the previous sync value. Input-to-status latency is 3 cycles.
- Status set: status[i] sets when IRQ_EN[i] and the selected edge occur. If a set and a W1C land in the same cycle, set wins. Clearing IRQ_EN does not clear status.
- gpio_interrupt is registered: |(status), 1 cycle after status.
- Reset (hba_reset=0, sampled on a clock edge): all registers, sync flops, status, FSM, gpio_dbus, gpio_xferack and gpio_interrupt go to 0. The previous-sync register loads 0, so a pin held high at reset release produces a rising edge. This is acceptable because IRQ_EN=0. Reset mid-transfer aborts it with no ack.

Optional Feature:
Macro GPIO_DEBOUNCE_EN.
- Defined: each synchronised pin feeds a counter. The filtered value updates only after the input has differed from it for DEBOUNCE_CYCLES consecutive cycles. IN_SIG and edge detection use the filtered value. Latency becomes 3+DEBOUNCE_CYCLES cycles. Counters reset to 0 and the filtered value to 0.
- Undefined: no filter; latency is 3 cycles.

Decomposition:
- Package hba_gpio_pkg holds:
  - func codes (FUNC_OUT_EN=0 ... FUNC_IRQ_STATUS=5)
  - FSM state enum (IDLE, ACK, WAIT)
  - NUM_FUNCS=6
- One sub-module, hba_gpio_pin_in, holds the per-pin synchroniser, optional debounce and edge detector. It outputs level, rise and fall. The top level instantiates it in a generate loop over NUM_PINS.

Test Plan:
1. NUM_PINS=12, PERIPH_ADDR=2: write 0xFF to r=0 (OUT_EN bank0) and 0x0F to r=1 (OUT_EN bank1) -> gpio_out_en=12'hFFF; reading r=1 returns 0x0F. Every write sees exactly one xferack pulse.
2. Hold hba_select for 5 cycles on one read -> a single ack in cycle 2, gpio_dbus=0 outside the ack cycle. Access to PERIPH_ADDR=3 -> never acked.
3. IRQ_EN[3]=1, IRQ_EDGE[3]=1, gpio_in_sig[3] goes 0->1 -> status[3]=1 3 cycles later, gpio_interrupt=1 the cycle after; W1C 0x08 to STATUS -> interrupt drops.
4. Falling-edge pin edge coincident with its W1C write -> status remains 1.
5. Read unmapped r=40 -> xferack with 0x00. Write r=40 -> no register changes.
6. Assert hba_reset=0 during the ACK state -> no ack, all outputs 0 the next cycle. With GPIO_DEBOUNCE_EN and DEBOUNCE_CYCLES=4, a 3-cycle glitch produces no status; a 6-cycle pulse sets status.
